// File: rtl/vdma_wr_burst_master.sv
// vdma_wr_burst_master: write-side DMA client for one DDR2 arbiter write port.
// Buffers a captured word stream in a show-ahead FIFO and writes one frame as
// fixed-size bursts at incrementing word addresses, pulsing frame_done at the end.
// Ports:
//   mem_clk, rst                         clock / async active-high reset
//   frame_start, cfg_base_addr,
//   cfg_frame_words                      frame control (sampled on accepted start)
//   in_valid, in_data, in_ready          input word stream
//   wr_burst_req/len/addr                burst request to the arbiter port
//   wr_burst_data_req, wr_burst_data     word consumption / FIFO head word
//   wr_burst_finish                      burst complete pulse
//   busy, frame_done, err                status
module vdma_wr_burst_master #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 25,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned FIFO_AW       = 9,
  parameter int unsigned FRAME_BITS    = 24
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [ADDR_BITS-1:0]     cfg_base_addr,
  input  logic [FRAME_BITS-1:0]    cfg_frame_words,
  input  logic                     in_valid,
  input  logic [MEM_DATA_BITS-1:0] in_data,
  output logic                     in_ready,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam logic [FRAME_BITS-1:0] BURST_LEN_F = FRAME_BITS'(BURST_LEN);
  localparam logic [CW-1:0]         DEPTH_C     = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_BITS-1:0]     addr_cnt_q, addr_cnt_d;
  logic [FRAME_BITS-1:0]    in_left_q, in_left_d;
  logic [FRAME_BITS-1:0]    wr_left_q, wr_left_d;
  logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [9:0]               pop_cnt_q, pop_cnt_d;
  logic [MEM_DATA_BITS-1:0] head_q, head_d;
  logic                     in_ready_q, in_ready_d;
  logic                     req_q, req_d;
  logic [9:0]               len_q, len_d;
  logic [ADDR_BITS-1:0]     baddr_q, baddr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic [MEM_DATA_BITS-1:0] mem_q [DEPTH];

  logic                     push, pop, pop_ok, in_burst;
  logic [FIFO_AW-1:0]       rd_next;
  logic [FRAME_BITS-1:0]    blen_f, wr_left_new;

  assign in_ready      = in_ready_q;
  assign wr_burst_req  = req_q;
  assign wr_burst_len  = len_q;
  assign wr_burst_addr = baddr_q;
  assign wr_burst_data = head_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign err           = err_q;

  // FIFO storage; not reset, occupancy is tracked by count_q
  always_ff @(posedge mem_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Next-state, FIFO bookkeeping and registered outputs
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    in_left_d  = in_left_q;
    wr_left_d  = wr_left_q;
    pop_cnt_d  = pop_cnt_q;
    head_d     = head_q;
    req_d      = req_q;
    len_d      = len_q;
    baddr_d    = baddr_q;
    err_d      = err_q;
    done_d     = 1'b0;

    // in_ready_q already folds in busy, remaining words and FIFO space
    push     = in_valid && in_ready_q;
    in_burst = (state_q == S_BURST);
    pop_ok   = (count_q != '0) && (pop_cnt_q < len_q);
    pop      = in_burst && wr_burst_data_req && pop_ok;
    rd_next  = rd_ptr_q + FIFO_AW'(1);

    blen_f      = (wr_left_q < BURST_LEN_F) ? wr_left_q : BURST_LEN_F;
    wr_left_new = wr_left_q - FRAME_BITS'(len_q);

    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);

    // Show-ahead head register; bypass in_data when the FIFO is (or becomes) empty
    if (count_q == '0) begin
      if (push) head_d = in_data;
    end else if (pop) begin
      if (count_q == CW'(1)) begin
        if (push) head_d = in_data;
      end else begin
        head_d = mem_q[rd_next];
      end
    end

    if (push) in_left_d = in_left_q - FRAME_BITS'(1);
    if (pop)  pop_cnt_d = pop_cnt_q + 10'd1;

    // Underflow or over-length data requests are dropped and flagged
    if (in_burst && wr_burst_data_req && !pop_ok) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          err_d = 1'b0;
          if (cfg_frame_words != '0) begin
            addr_cnt_d = cfg_base_addr;
            in_left_d  = cfg_frame_words;
            wr_left_d  = cfg_frame_words;
            state_d    = S_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (frame_start) err_d = 1'b1;
        if (FRAME_BITS'(count_q) >= blen_f) begin
          len_d     = 10'(blen_f);
          baddr_d   = addr_cnt_q;
          req_d     = 1'b1;
          pop_cnt_d = '0;
          state_d   = S_BURST;
        end
      end
      S_BURST: begin
        if (frame_start) err_d = 1'b1;
        if (wr_burst_finish) begin
          req_d      = 1'b0;
          addr_cnt_d = addr_cnt_q + ADDR_BITS'(len_q);
          wr_left_d  = wr_left_new;
          if (wr_left_new == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    in_ready_d = busy_d && (in_left_d != '0) && (count_d != DEPTH_C);
  end

  // State and output registers
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_cnt_q <= '0;
      in_left_q  <= '0;
      wr_left_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pop_cnt_q  <= '0;
      head_q     <= '0;
      in_ready_q <= 1'b0;
      req_q      <= 1'b0;
      len_q      <= '0;
      baddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      in_left_q  <= in_left_d;
      wr_left_q  <= wr_left_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pop_cnt_q  <= pop_cnt_d;
      head_q     <= head_d;
      in_ready_q <= in_ready_d;
      req_q      <= req_d;
      len_q      <= len_d;
      baddr_q    <= baddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_vdma_wr_burst_master.sv
// Bench for vdma_wr_burst_master: directed frames with a word-stream driver,
// an arbiter-port responder and expected-word / expected-burst scoreboards.
module tb_vdma_wr_burst_master;
  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 25;
  localparam int unsigned BL  = 64;
  localparam int unsigned FAW = 6;
  localparam int unsigned FB  = 24;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [FB-1:0] cfg_frame_words = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          wr_burst_req;
  logic [9:0]    wr_burst_len;
  logic [AW-1:0] wr_burst_addr;
  logic          wr_burst_data_req = 1'b0;
  logic [DW-1:0] wr_burst_data;
  logic          wr_burst_finish = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          err;

  vdma_wr_burst_master #(
    .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_LEN(BL), .FIFO_AW(FAW), .FRAME_BITS(FB)
  ) dut (
    .mem_clk(mem_clk), .rst(rst), .frame_start(frame_start),
    .cfg_base_addr(cfg_base_addr), .cfg_frame_words(cfg_frame_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 mem_clk = ~mem_clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_baddr[$];
  logic [9:0]    exp_blen[$];

  bit          drv_en = 1'b0;
  int          drv_total = 0;
  int          drv_sent = 0;
  int unsigned seq = 0;
  int          delay = 2;
  int          done_cnt = 0;
  int          req_cnt = 0;
  bit          req_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int unsigned s);
    return {s, ~s};
  endfunction

  // Word-stream source: offers words back to back, records accepted ones
  always @(negedge mem_clk) begin
    if (rst || !drv_en) begin
      in_valid = 1'b0;
    end else if (drv_sent < drv_total) begin
      in_valid = 1'b1;
      in_data  = word_of(seq);
      if (in_ready) begin
        exp_data.push_back(in_data);
        seq++;
        drv_sent++;
      end
    end else begin
      in_valid = 1'b0;
    end
  end

  // Arbiter-port responder: checks each burst request, consumes its words, finishes
  int            rs = 0;
  int            wcnt = 0;
  int            k = 0;
  logic [9:0]    cur_len;
  logic [AW-1:0] cur_addr;
  always @(negedge mem_clk) begin
    logic [DW-1:0] e;
    logic [AW-1:0] ea;
    logic [9:0]    el;
    if (rst) begin
      rs = 0;
      wr_burst_data_req = 1'b0;
      wr_burst_finish   = 1'b0;
    end else begin
      case (rs)
        0: begin
          wr_burst_data_req = 1'b0;
          wr_burst_finish   = 1'b0;
          if (wr_burst_req) begin
            cur_len  = wr_burst_len;
            cur_addr = wr_burst_addr;
            ea = (exp_baddr.size() != 0) ? exp_baddr.pop_front() : 'x;
            el = (exp_blen.size() != 0) ? exp_blen.pop_front() : 'x;
            check("burst_addr", 64'(cur_addr), 64'(ea));
            check("burst_len", 64'(cur_len), 64'(el));
            wcnt = delay;
            rs = 1;
          end
        end
        1: begin
          if (wcnt > 1) wcnt--;
          else begin
            rs = 2;
            k = 0;
          end
        end
        2: begin
          wr_burst_data_req = 1'b1;
          e = (exp_data.size() != 0) ? exp_data.pop_front() : 'x;
          check("wr_data", wr_burst_data, e);
          k++;
          if (k == int'(cur_len)) begin
            check("addr_stable", 64'(wr_burst_addr), 64'(cur_addr));
            check("len_stable", 64'(wr_burst_len), 64'(cur_len));
            rs = 3;
          end
        end
        3: begin
          wr_burst_data_req = 1'b0;
          wr_burst_finish   = 1'b1;
          rs = 4;
        end
        default: begin
          wr_burst_finish = 1'b0;
          check("req_drop", 64'(wr_burst_req), 64'(0));
          rs = 0;
        end
      endcase
    end
  end

  // Event counters for frame_done pulses and request rising edges
  always @(negedge mem_clk) begin
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (wr_burst_req && !req_prev) req_cnt++;
    end
    req_prev = wr_burst_req;
  end

  task automatic push_bursts(input logic [AW-1:0] base, input int words);
    logic [AW-1:0] a = base;
    int left = words;
    int l;
    while (left > 0) begin
      l = (left < int'(BL)) ? left : int'(BL);
      exp_baddr.push_back(a);
      exp_blen.push_back(10'(l));
      a = a + AW'(l);
      left -= l;
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input int words, input int offered);
    push_bursts(base, words);
    @(negedge mem_clk);
    cfg_base_addr   = base;
    cfg_frame_words = FB'(words);
    frame_start     = 1'b1;
    drv_total       = offered;
    drv_sent        = 0;
    drv_en          = 1'b1;
    @(negedge mem_clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge mem_clk);
      n++;
    end
    repeat (5) @(negedge mem_clk);
    check(tag, 64'(done_cnt), 64'(target));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_data_left"}, 64'(exp_data.size()), 64'(0));
    check({tag, "_bursts_left"}, 64'(exp_baddr.size()), 64'(0));
    drv_en = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!wr_burst_req && n < 2000) begin
      @(negedge mem_clk);
      n++;
    end
    check("req_seen", 64'(wr_burst_req), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 64'(wr_burst_req), 64'(0));
    check({tag, "_len"}, 64'(wr_burst_len), 64'(0));
    check({tag, "_addr"}, 64'(wr_burst_addr), 64'(0));
    check({tag, "_data"}, wr_burst_data, 64'(0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(frame_done), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
  endtask

  initial begin
    int base_done;
    int base_req;

    repeat (2) @(negedge mem_clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge mem_clk);

    // Full frame of four bursts
    start_frame(25'h100, 256, 256);
    wait_done("frame256_done", 1);
    check("frame256_err", 64'(err), 64'(0));
    check("frame256_req_cnt", 64'(req_cnt), 64'(4));

    // Short tail burst; extra offered words must be refused
    start_frame(25'h800, 100, 110);
    while (drv_sent < 100 && busy) @(negedge mem_clk);
    @(negedge mem_clk);
    check("tail_in_ready_low", 64'(in_ready), 64'(0));
    check("tail_busy", 64'(busy), 64'(1));
    wait_done("frame100_done", 2);
    check("tail_accepted", 64'(drv_sent), 64'(100));

    // Stalled consumer: FIFO fills to depth and backpressures
    delay = 200;
    start_frame(25'h400, 128, 128);
    repeat (120) @(negedge mem_clk);
    check("stall_accepted", 64'(drv_sent), 64'(64));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    check("stall_req", 64'(wr_burst_req), 64'(1));
    delay = 2;
    wait_done("stall_done", 3);
    check("stall_total", 64'(drv_sent), 64'(128));

    // Address wrap at top of the word address space
    start_frame(25'h1FFFFC0, 128, 128);
    wait_done("wrap_done", 4);

    // frame_start while busy is ignored but flagged
    start_frame(25'h200, 128, 128);
    wait_req();
    @(negedge mem_clk);
    cfg_base_addr   = 25'h999;
    cfg_frame_words = 24'd50;
    frame_start     = 1'b1;
    @(negedge mem_clk);
    frame_start = 1'b0;
    check("busy_start_err", 64'(err), 64'(1));
    wait_done("busy_start_done", 5);
    check("busy_start_err_sticky", 64'(err), 64'(1));

    // Zero-word frame: immediate frame_done, no request, clears err
    base_req = req_cnt;
    @(negedge mem_clk);
    cfg_frame_words = '0;
    frame_start     = 1'b1;
    @(negedge mem_clk);
    frame_start = 1'b0;
    check("zero_done_pulse", 64'(frame_done), 64'(1));
    check("zero_err_cleared", 64'(err), 64'(0));
    @(negedge mem_clk);
    check("zero_done_single", 64'(frame_done), 64'(0));
    repeat (5) @(negedge mem_clk);
    check("zero_no_req", 64'(req_cnt), 64'(base_req));
    check("zero_idle", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of a burst
    start_frame(25'h300, 128, 128);
    wait_req();
    @(negedge mem_clk);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_data.delete();
    exp_baddr.delete();
    exp_blen.delete();
    drv_en = 1'b0;
    repeat (3) @(negedge mem_clk);
    rst = 1'b0;
    repeat (2) @(negedge mem_clk);
    base_done = done_cnt;
    start_frame(25'h0, 64, 64);
    wait_done("post_rst_done", base_done + 1);
    check("post_rst_err", 64'(err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vdma_wr_burst_master.md
Name: vdma_wr_burst_master

Overview:
- Write-side DMA client for one chN_wr port of the 8-port DDR2 arbitrated controller.
- Accepts a word stream from the video capture path and buffers it in an internal show-ahead FIFO.
- Issues fixed-size write bursts with incrementing word addresses until one frame is written, then reports completion.
- Sits directly upstream of a write-arbiter port, in the controller's phy_clk domain, connected to this block's mem_clk.

Parameters:
- MEM_DATA_BITS, 64, word width; matches the controller's port data width.
- ADDR_BITS, 25, word address width.
- BURST_LEN, 64, nominal burst length in words; range 1..512.
- FIFO_AW, 9, FIFO address bits; depth = 2^FIFO_AW and must be at least BURST_LEN.
- FRAME_BITS, 24, width of the frame word count.

Ports:
- mem_clk  in  1  controller phy_clk; sole clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle pulse; starts a frame.
- cfg_base_addr  in  ADDR_BITS  frame base word address; sampled on an accepted frame_start.
- cfg_frame_words  in  FRAME_BITS  words in the frame; sampled on an accepted frame_start.
- in_valid  in  1  input word valid.
- in_data  in  MEM_DATA_BITS  input word.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- wr_burst_req  out  1  burst request to the arbiter port.
- wr_burst_len  out  10  words in the current burst.
- wr_burst_addr  out  ADDR_BITS  start word address of the current burst.
- wr_burst_data_req  in  1  controller consumes one word this cycle.
- wr_burst_data  out  MEM_DATA_BITS  FIFO head word; valid in the same cycle as wr_burst_data_req.
- wr_burst_finish  in  1  single-cycle pulse; current burst complete.
- busy  out  1  frame in progress.
- frame_done  out  1  single-cycle pulse when a frame completes.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, including wr_burst_len and wr_burst_addr. FIFO is emptied. All counters are cleared. State is IDLE.
- Reset mid-burst aborts immediately. No finish is awaited.
- State IDLE:
  - A frame_start with cfg_frame_words != 0 loads addr_cnt = cfg_base_addr, in_left = cfg_frame_words and wr_left = cfg_frame_words, then moves to WAIT.
  - A frame_start with cfg_frame_words == 0 pulses frame_done on the next cycle and stays in IDLE.
  - busy = (state != IDLE).
- Input side:
  - in_ready = busy && (in_left != 0) && FIFO not full.
  - Each accepted word pushes to the FIFO and decrements in_left.
  - Words beyond the frame are never accepted.
- Burst length:
  - blen = min(BURST_LEN, wr_left), computed in FRAME_BITS width, then truncated to 10 bits.
- State WAIT:
  - When fifo_count >= blen, register wr_burst_len = blen and wr_burst_addr = addr_cnt, set wr_burst_req = 1 on the next cycle, and move to BURST.
- State BURST:
  - wr_burst_req is held at 1 until wr_burst_finish.
  - wr_burst_len and wr_burst_addr are stable while wr_burst_req = 1.
  - Each wr_burst_data_req pops one FIFO word. Pushes and pops in the same cycle are both performed and fifo_count is unchanged.
  - On wr_burst_finish: wr_burst_req = 0 on the next cycle, addr_cnt += wr_burst_len (ADDR_BITS, wraps modulo 2^ADDR_BITS), and wr_left -= wr_burst_len.
  - If the new wr_left == 0: frame_done pulses on the cycle after finish and the state returns to IDLE. Otherwise the state returns to WAIT.
- Request spacing: at least one idle cycle of wr_burst_req occurs between consecutive bursts.
- Error conditions (all set err):
  - wr_burst_data_req with an empty FIFO: no pop; wr_burst_data holds its last value.
  - More than wr_burst_len data_req pulses in one burst: extra pulses are ignored.
  - frame_start while busy: the pulse is ignored.
- err is cleared only by rst or by an accepted frame_start.
- wr_burst_finish or wr_burst_data_req outside BURST is ignored.

Test Plan:
- BURST_LEN=64, cfg_frame_words=256, base 0x100, continuous input, data_req returned 2 cycles after req → 4 bursts at 0x100/0x140/0x180/0x1C0, each len 64, data in order, exactly one frame_done, err=0.
- cfg_frame_words=100 → bursts of len 64 then len 36 at base+64; in_ready drops after 100 accepted words.
- FIFO_AW=6 with data_req stalled 200 cycles → in_ready=0 once 64 words are buffered, no word lost, and the stream resumes when popping starts.
- cfg_base_addr=0x1FFFFC0, 128 words → second burst address wraps to 0x0000000.
- frame_start mid-burst → ignored, err=1, current frame completes normally; the next frame_start clears err.
- rst asserted while wr_burst_req=1 → all outputs 0 asynchronously; after rst release a new frame (base 0x0, 64 words) writes correctly.
- cfg_frame_words=0 → frame_done pulse one cycle after frame_start, no wr_burst_req.
